// File: rtl/memory_access_pkg.sv
// Shared constants for the memory-stage access unit: data width, funct3 size codes, FSM states.
package memory_access_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/memory_access_load_align.sv
// Load lane selection and sign/zero extension of a read word.
module memory_access_load_align
  import memory_access_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata >> {offset, 3'b000});
    half_lane = 16'(rdata >> {offset[1], 4'b0000});
    case (funct3[1:0])
      SZ_B:    value = funct3[2] ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_H:    value = funct3[2] ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-stage data-access unit: single-outstanding req/ack port, load alignment, stall request.
// Optional build macro MEM_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of aligning them.
module memory_access
  import memory_access_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst,
  input  logic            ED_mem_read_i,
  input  logic            ED_mem_write_i,
  input  logic [2:0]      ED_funct3_i,
  input  logic [XLEN-1:0] ED_valE_i,
  input  logic [XLEN-1:0] ED_valB_i,
  input  logic            M_stall_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_ack_i,
  output logic [XLEN-1:0] M_valM_o,
  output logic            M_busy_o,
  output logic            M_misalign_o
);

  // state  | meaning
  // IDLE   | waiting for a load/store in the E/M register
  // REQ    | bus request outstanding, waiting for ack
  // DONE   | result held until the M/W register captures it

  mem_state_e      state_q, state_d;
  logic            mem_op, misalign, start;
  logic [1:0]      off_aligned, off_q;
  logic [2:0]      funct3_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q, wdata_q, wdata_d, result_q, load_val;
  logic [3:0]      wstrb_q, wstrb_d;

  assign mem_op = ED_mem_read_i | ED_mem_write_i;

  always_comb begin
    case (ED_funct3_i[1:0])
      SZ_B:    off_aligned = ED_valE_i[1:0];
      SZ_H:    off_aligned = {ED_valE_i[1], 1'b0};
      default: off_aligned = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic raw_misalign;
  assign raw_misalign = (ED_funct3_i[1:0] == SZ_H) ? ED_valE_i[0]
                      : (ED_funct3_i[1] && (ED_valE_i[1:0] != 2'b00));
  assign misalign = (state_q == S_IDLE) && mem_op && raw_misalign;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (ED_funct3_i[1:0])
      SZ_B: begin
        wstrb_d = 4'b0001 << off_aligned;
        wdata_d = {4{ED_valB_i[7:0]}};
      end
      SZ_H: begin
        wstrb_d = 4'b0011 << off_aligned;
        wdata_d = {2{ED_valB_i[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = ED_valB_i;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    M_busy_o = 1'b0;
    start    = 1'b0;
    case (state_q)
      S_IDLE: if (mem_op && !misalign) begin
        state_d  = S_REQ;
        M_busy_o = 1'b1;
        start    = 1'b1;
      end
      S_REQ: begin
        M_busy_o = 1'b1;
        if (dmem_ack_i) state_d = S_DONE;
      end
      S_DONE:  if (!M_stall_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  memory_access_load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .offset (off_q),
    .funct3 (funct3_q),
    .value  (load_val)
  );

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      off_q    <= '0;
      funct3_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q   <= {ED_valE_i[XLEN-1:2], 2'b00};
        we_q     <= ED_mem_write_i;
        wdata_q  <= ED_mem_write_i ? wdata_d : '0;
        wstrb_q  <= ED_mem_write_i ? wstrb_d : 4'b0000;
        off_q    <= off_aligned;
        funct3_q <= ED_funct3_i;
      end
      // Stores complete with a zero result so writeback sees a clean value.
      if (state_q == S_REQ && dmem_ack_i) result_q <= we_q ? '0 : load_val;
    end
  end

  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_wstrb_o = wstrb_q;
  assign M_valM_o     = (state_q == S_DONE) ? result_q : '0;
  assign M_misalign_o = misalign;

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access with hand-computed expected values.
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        ED_mem_read_i = 1'b0, ED_mem_write_i = 1'b0;
  logic [2:0]  ED_funct3_i = 3'b000;
  logic [31:0] ED_valE_i = '0, ED_valB_i = '0;
  logic        M_stall_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] M_valM_o;
  logic        M_busy_o, M_misalign_o;

  int checks = 0;
  int errors = 0;

  memory_access dut (
    .clk_i(clk_i), .rst(rst),
    .ED_mem_read_i(ED_mem_read_i), .ED_mem_write_i(ED_mem_write_i),
    .ED_funct3_i(ED_funct3_i), .ED_valE_i(ED_valE_i), .ED_valB_i(ED_valB_i),
    .M_stall_i(M_stall_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .M_valM_o(M_valM_o), .M_busy_o(M_busy_o), .M_misalign_o(M_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one access from IDLE; ack arrives after 'waits' request cycles without ack.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] valb,
                           input logic [31:0] rdata, input int waits,
                           output int req_cyc, output int busy_cyc,
                           output logic [31:0] valm, output logic [3:0] strb,
                           output logic [31:0] wd, output logic [31:0] ad,
                           output logic we);
    bit done = 0;
    ED_mem_read_i = rd; ED_mem_write_i = wr; ED_funct3_i = f3;
    ED_valE_i = addr; ED_valB_i = valb;
    req_cyc = 0; busy_cyc = 0; valm = 'x; strb = 'x; wd = 'x; ad = 'x; we = 1'bx;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (M_busy_o) busy_cyc++;
      if (dmem_req_o) begin
        if (req_cyc == 0) begin
          strb = dmem_wstrb_o; wd = dmem_wdata_o; ad = dmem_addr_o; we = dmem_we_o;
        end
        req_cyc++;
        dmem_ack_i   = (req_cyc > waits);
        dmem_rdata_i = rdata;
      end else begin
        dmem_ack_i = 1'b0;
      end
      if (cyc > 0 && !M_busy_o) begin
        valm = M_valM_o;
        done = 1;
      end
      @(posedge clk_i);
      #1;
      dmem_ack_i = 1'b0;
    end
    ED_mem_read_i = 1'b0; ED_mem_write_i = 1'b0;
    if (!done) chk("access_timeout", 32'd0, 32'd1);
  endtask

  int          rq, bz;
  logic [31:0] vm, wd, ad;
  logic [3:0]  sb;
  logic        we;
  int          extra_req;

  initial begin
    tick();
    tick();
    chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
    chk("rst_we", {31'b0, dmem_we_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_wstrb", {28'b0, dmem_wstrb_o}, 32'd0);
    chk("rst_valm", M_valM_o, 32'd0);
    chk("rst_busy", {31'b0, M_busy_o}, 32'd0);
    chk("rst_misalign", {31'b0, M_misalign_o}, 32'd0);
    rst = 1'b0;
    tick();

    do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, rq, bz, vm, sb, wd, ad, we);
    chk("lw_req_cycles", rq, 32'd3);
    chk("lw_busy_cycles", bz, 32'd4);
    chk("lw_valm", vm, 32'hDEADBEEF);
    chk("lw_addr", ad, 32'h100);
    chk("lw_we", {31'b0, we}, 32'd0);
    #1;
    chk("idle_valm", M_valM_o, 32'd0);
    chk("idle_busy", {31'b0, M_busy_o}, 32'd0);

    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, rq, bz, vm, sb, wd, ad, we);
    chk("lb_req_cycles", rq, 32'd1);
    chk("lb_busy_cycles", bz, 32'd2);
    chk("lb_valm", vm, 32'hFFFFFF80);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, rq, bz, vm, sb, wd, ad, we);
    chk("lbu_valm", vm, 32'h00000080);
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 1, rq, bz, vm, sb, wd, ad, we);
    chk("lhu_valm", vm, 32'h00008012);
    do_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0, rq, bz, vm, sb, wd, ad, we);
    chk("lh_hi_valm", vm, 32'hFFFF8012);
    do_access(1, 0, 3'b001, 32'h100, 32'h0, 32'h80123456, 0, rq, bz, vm, sb, wd, ad, we);
    chk("lh_lo_valm", vm, 32'h00003456);
    do_access(1, 0, 3'b000, 32'h101, 32'h0, 32'h80123456, 0, rq, bz, vm, sb, wd, ad, we);
    chk("lb_lane1_valm", vm, 32'h00000034);

    do_access(0, 1, 3'b000, 32'h101, 32'h000000AB, 32'hFFFFFFFF, 0, rq, bz, vm, sb, wd, ad, we);
    chk("sb_wstrb", {28'b0, sb}, 32'b0010);
    chk("sb_wdata", wd, 32'hABABABAB);
    chk("sb_we", {31'b0, we}, 32'd1);
    chk("sb_addr", ad, 32'h100);
    chk("sb_valm", vm, 32'd0);
    do_access(0, 1, 3'b001, 32'h206, 32'h55661234, 32'h0, 1, rq, bz, vm, sb, wd, ad, we);
    chk("sh_wstrb", {28'b0, sb}, 32'b1100);
    chk("sh_wdata", wd, 32'h12341234);
    chk("sh_addr", ad, 32'h204);
    do_access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 0, rq, bz, vm, sb, wd, ad, we);
    chk("sw_wstrb", {28'b0, sb}, 32'b1111);
    chk("sw_wdata", wd, 32'hCAFEF00D);

    // Result must persist while M/W is stalled, with no new request.
    ED_mem_read_i = 1; ED_funct3_i = 3'b010; ED_valE_i = 32'h200; M_stall_i = 1'b1;
    tick();
    chk("stall_req", {31'b0, dmem_req_o}, 32'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h11223344;
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    extra_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dmem_req_o) extra_req++;
      chk("stall_valm", M_valM_o, 32'h11223344);
      chk("stall_busy", {31'b0, M_busy_o}, 32'd0);
      tick();
    end
    chk("stall_no_req", extra_req, 32'd0);
    M_stall_i = 1'b0;
    #1;
    chk("stall_release_valm", M_valM_o, 32'h11223344);
    tick();
    ED_mem_read_i = 1'b0;
    #1;
    chk("after_stall_valm", M_valM_o, 32'd0);

    // Reset during REQ together with ack, then a late ack.
    ED_mem_read_i = 1; ED_funct3_i = 3'b010; ED_valE_i = 32'h300;
    tick();
    chk("rstreq_req", {31'b0, dmem_req_o}, 32'd1);
    rst = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h99999999;
    tick();
    rst = 1'b0; ED_mem_read_i = 1'b0;
    #1;
    chk("rstreq_req_drop", {31'b0, dmem_req_o}, 32'd0);
    chk("rstreq_valm", M_valM_o, 32'd0);
    chk("rstreq_busy", {31'b0, M_busy_o}, 32'd0);
    tick();
    chk("late_ack_req", {31'b0, dmem_req_o}, 32'd0);
    chk("late_ack_valm", M_valM_o, 32'd0);
    dmem_ack_i = 1'b0;
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    ED_mem_read_i = 1; ED_funct3_i = 3'b010; ED_valE_i = 32'h102;
    #1;
    chk("mis_flag", {31'b0, M_misalign_o}, 32'd1);
    chk("mis_busy", {31'b0, M_busy_o}, 32'd0);
    chk("mis_valm", M_valM_o, 32'd0);
    tick();
    chk("mis_no_req", {31'b0, dmem_req_o}, 32'd0);
    ED_mem_read_i = 1'b0;
    tick();
`else
    do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'hA5A5F00D, 0, rq, bz, vm, sb, wd, ad, we);
    chk("mis_addr", ad, 32'h100);
    chk("mis_valm", vm, 32'hA5A5F00D);
    chk("mis_req_cycles", rq, 32'd1);
    #1;
    chk("mis_flag", {31'b0, M_misalign_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
